// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves rs1/rs2 from the forwarding network or the
// register file, detects load-use hazards, and holds the fetched operands in a
// single valid/ready output register toward execute.
module operand_fetch #(
    parameter int REGISTER_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      flush,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic                      in_rd_we,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,

    output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr,
    input  logic [REGISTER_WIDTH-1:0] rf_rs1_data,
    input  logic [REGISTER_WIDTH-1:0] rf_rs2_data,

    input  logic                      ex_fwd_we,
    input  logic                      ex_fwd_pending,
    input  logic [REG_ADDR_WIDTH-1:0] ex_fwd_rd,
    input  logic [REGISTER_WIDTH-1:0] ex_fwd_data,

    input  logic                      mem_fwd_we,
    input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
    input  logic [REGISTER_WIDTH-1:0] mem_fwd_data,

    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [REGISTER_WIDTH-1:0] wb_data,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REGISTER_WIDTH-1:0] out_rs1_data,
    output logic [REGISTER_WIDTH-1:0] out_rs2_data,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_rd_we,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,

    output logic [15:0]               stall_cnt
);

    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

    // Youngest producer wins: execute, then memory, then writeback, then the
    // register file. x0 is hardwired to zero regardless of any producer.
    function automatic logic [REGISTER_WIDTH-1:0] resolve_operand(
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic [REGISTER_WIDTH-1:0] rf_data,
        input logic                      ex_we,
        input logic [REG_ADDR_WIDTH-1:0] ex_rd,
        input logic [REGISTER_WIDTH-1:0] ex_data,
        input logic                      mem_we,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd,
        input logic [REGISTER_WIDTH-1:0] mem_data,
        input logic                      wr_we,
        input logic [REG_ADDR_WIDTH-1:0] wr_rd,
        input logic [REGISTER_WIDTH-1:0] wr_data
    );
        if (addr == X0) begin
            return '0;
        end else if (ex_we && (ex_rd == addr)) begin
            return ex_data;
        end else if (mem_we && (mem_rd == addr)) begin
            return mem_data;
        end else if (wr_we && (wr_rd == addr)) begin
            return wr_data;
        end
        return rf_data;
    endfunction

    // The execute stage matches but its result (a load) is not ready yet.
    function automatic logic load_use(
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic                      ex_we,
        input logic                      ex_pend,
        input logic [REG_ADDR_WIDTH-1:0] ex_rd
    );
        return (addr != X0) && ex_we && ex_pend && (ex_rd == addr);
    endfunction

    logic                      out_valid_q, out_valid_d;
    logic [REGISTER_WIDTH-1:0] out_rs1_q, out_rs1_d;
    logic [REGISTER_WIDTH-1:0] out_rs2_q, out_rs2_d;
    logic [REG_ADDR_WIDTH-1:0] out_rd_addr_q, out_rd_addr_d;
    logic                      out_rd_we_q, out_rd_we_d;
    logic [CTRL_WIDTH-1:0]     out_ctrl_q, out_ctrl_d;
    logic [15:0]               stall_cnt_q, stall_cnt_d;

    logic                      hazard;
    logic                      accept;
    logic [REGISTER_WIDTH-1:0] rs1_res;
    logic [REGISTER_WIDTH-1:0] rs2_res;

    assign rf_rs1_addr = in_rs1_addr;
    assign rf_rs2_addr = in_rs2_addr;

    // Operand resolution, hazard detection and input handshake.
    always_comb begin
        rs1_res = resolve_operand(in_rs1_addr, rf_rs1_data,
                                  ex_fwd_we, ex_fwd_rd, ex_fwd_data,
                                  mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                                  wb_we, wb_rd, wb_data);
        rs2_res = resolve_operand(in_rs2_addr, rf_rs2_data,
                                  ex_fwd_we, ex_fwd_rd, ex_fwd_data,
                                  mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                                  wb_we, wb_rd, wb_data);
        hazard  = load_use(in_rs1_addr, ex_fwd_we, ex_fwd_pending, ex_fwd_rd) ||
                  load_use(in_rs2_addr, ex_fwd_we, ex_fwd_pending, ex_fwd_rd);
        in_ready = start && !hazard && (!out_valid_q || out_ready) && !flush;
        accept   = in_valid && in_ready;
    end

    // Next state of the output register and stall counter; everything holds
    // while start is low, and flush outranks both load and hold.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_rs1_d     = out_rs1_q;
        out_rs2_d     = out_rs2_q;
        out_rd_addr_d = out_rd_addr_q;
        out_rd_we_d   = out_rd_we_q;
        out_ctrl_d    = out_ctrl_q;
        stall_cnt_d   = stall_cnt_q;
        if (start) begin
            if (in_valid && hazard && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (flush) begin
                out_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_rs1_d     = rs1_res;
                out_rs2_d     = rs2_res;
                out_rd_addr_d = in_rd_addr;
                out_rd_we_d   = in_rd_we;
                out_ctrl_d    = in_ctrl;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_rd_addr_q <= '0;
            out_rd_we_q   <= 1'b0;
            out_ctrl_q    <= '0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_rs1_q     <= out_rs1_d;
            out_rs2_q     <= out_rs2_d;
            out_rd_addr_q <= out_rd_addr_d;
            out_rd_we_q   <= out_rd_we_d;
            out_ctrl_q    <= out_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_rs1_q;
    assign out_rs2_data = out_rs2_q;
    assign out_rd_addr  = out_rd_addr_q;
    assign out_rd_we    = out_rd_we_q;
    assign out_ctrl     = out_ctrl_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the stage.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n, start, flush;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_rd_we;
    logic [31:0] in_ctrl;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        ex_fwd_we, ex_fwd_pending;
    logic [4:0]  ex_fwd_rd;
    logic [31:0] ex_fwd_data;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic [31:0] out_ctrl;
    logic [15:0] stall_cnt;

    logic [31:0] rf [32];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the instruction the stage should be holding.
    logic        m_vld;
    logic [31:0] m_rs1, m_rs2, m_ctrl;
    logic [4:0]  m_rd;
    logic        m_rdwe;
    int          m_cnt;

    operand_fetch #(
        .REGISTER_WIDTH(32),
        .REG_ADDR_WIDTH(5),
        .CTRL_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_ctrl(in_ctrl),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_pending(ex_fwd_pending),
        .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value a source register should read: start from the register file and
    // let each progressively younger producer overwrite it.
    function automatic logic [31:0] ref_operand(input logic [4:0] a);
        logic [31:0] v;
        v = rf[a];
        if (wb_we && wb_rd == a)           v = wb_data;
        if (mem_fwd_we && mem_fwd_rd == a) v = mem_fwd_data;
        if (ex_fwd_we && ex_fwd_rd == a)   v = ex_fwd_data;
        if (a == 5'd0)                     v = 32'd0;
        return v;
    endfunction

    function automatic logic ref_stall(input logic [4:0] a);
        return (a != 5'd0) && ex_fwd_we && ex_fwd_pending && (ex_fwd_rd == a);
    endfunction

    // One clock: inputs are already driven; check combinational outputs,
    // advance the model, clock, then check the registered outputs.
    task automatic step();
        logic hz, rdy;
        logic [31:0] e1, e2;
        #1;
        e1  = ref_operand(in_rs1_addr);
        e2  = ref_operand(in_rs2_addr);
        hz  = ref_stall(in_rs1_addr) || ref_stall(in_rs2_addr);
        rdy = start && !hz && (!m_vld || out_ready) && !flush;
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("rf_rs1_addr", 64'(rf_rs1_addr), 64'(in_rs1_addr));
        check("rf_rs2_addr", 64'(rf_rs2_addr), 64'(in_rs2_addr));
        if (!rst_n) begin
            m_vld = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_rdwe = 1'b0;
            m_ctrl = '0; m_cnt = 0;
        end else if (start) begin
            if (in_valid && hz && m_cnt < 65535) m_cnt++;
            if (flush) begin
                m_vld = 1'b0;
            end else if (in_valid && rdy) begin
                m_vld = 1'b1; m_rs1 = e1; m_rs2 = e2; m_rd = in_rd_addr;
                m_rdwe = in_rd_we; m_ctrl = in_ctrl;
            end else if (m_vld && out_ready) begin
                m_vld = 1'b0;
            end
        end
        @(posedge clk);
        if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
        #1;
        check("out_valid", 64'(out_valid), 64'(m_vld));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (m_vld || !rst_n) begin
            check("out_rs1_data", 64'(out_rs1_data), 64'(m_rs1));
            check("out_rs2_data", 64'(out_rs2_data), 64'(m_rs2));
            check("out_rd_addr", 64'(out_rd_addr), 64'(m_rd));
            check("out_rd_we", 64'(out_rd_we), 64'(m_rdwe));
            check("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
        end
    endtask

    task automatic clear_fwd();
        ex_fwd_we = 0; ex_fwd_pending = 0; ex_fwd_rd = 0; ex_fwd_data = 0;
        mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; step(); rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rf[0] = 32'hDEAD_BEEF;
        m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rdwe = 0; m_ctrl = 0; m_cnt = 0;
        rst_n = 0; start = 0; flush = 0; in_valid = 0; out_ready = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_rd_we = 0; in_ctrl = 0;
        clear_fwd();
        @(posedge clk); #1;
        step(); step();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_ctrl", 64'(out_ctrl), 64'd0);
        rst_n = 1;

        // Plain register-file read.
        start = 1; out_ready = 1; in_valid = 1;
        rf[3] = 5; rf[4] = 7; in_rs1_addr = 3; in_rs2_addr = 4;
        in_rd_addr = 9; in_rd_we = 1; in_ctrl = 32'hA5A5_0001;
        step();
        check("plain rs1", 64'(out_rs1_data), 64'd5);
        check("plain rs2", 64'(out_rs2_data), 64'd7);

        // Forwarding priority ex > mem > wb > rf.
        ex_fwd_we = 1; ex_fwd_rd = 3; ex_fwd_data = 9;
        mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 8;
        wb_we = 1; wb_rd = 3; wb_data = 6;
        step();
        check("prio ex", 64'(out_rs1_data), 64'd9);
        ex_fwd_we = 0; step();
        check("prio mem", 64'(out_rs1_data), 64'd8);
        mem_fwd_we = 0; step();
        check("prio wb", 64'(out_rs1_data), 64'd6);
        clear_fwd();

        // x0 never forwards and never stalls.
        in_rs1_addr = 0;
        ex_fwd_we = 1; ex_fwd_pending = 1; ex_fwd_rd = 0; ex_fwd_data = 32'hFFFF_FFFF;
        mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 32'hFFFF_FFFF;
        wb_we = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
        step();
        check("x0 rs1", 64'(out_rs1_data), 64'd0);
        check("x0 stall", 64'(stall_cnt), 64'd0);
        clear_fwd();

        // Load-use stall for three cycles, then release.
        do_reset();
        in_rs1_addr = 1; in_rs2_addr = 4;
        ex_fwd_we = 1; ex_fwd_pending = 1; ex_fwd_rd = 4; ex_fwd_data = 32'h0000_1234;
        repeat (3) step();
        check("loaduse stall_cnt", 64'(stall_cnt), 64'd3);
        check("loaduse bubble", 64'(out_valid), 64'd0);
        ex_fwd_pending = 0;
        step();
        check("loaduse rs2", 64'(out_rs2_data), 64'h1234);
        clear_fwd();

        // Backpressure holds the output; flush drops it.
        out_ready = 0; in_rs1_addr = 5; in_rs2_addr = 6; in_ctrl = 32'h0BAD_F00D;
        repeat (4) step();
        check("bp hold rs2", 64'(out_rs2_data), 64'h1234);
        flush = 1; step(); flush = 0;
        check("flush clears", 64'(out_valid), 64'd0);

        // Reset while stalled with a held instruction.
        do_reset();
        step();
        in_rs2_addr = 4; ex_fwd_we = 1; ex_fwd_pending = 1; ex_fwd_rd = 4;
        repeat (10) step();
        check("pre-reset cnt", 64'(stall_cnt), 64'd10);
        check("pre-reset valid", 64'(out_valid), 64'd1);
        do_reset();
        check("post-reset cnt", 64'(stall_cnt), 64'd0);
        check("post-reset valid", 64'(out_valid), 64'd0);
        clear_fwd();

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            start          = ($urandom_range(0, 9) != 0);
            flush          = ($urandom_range(0, 19) == 0);
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            in_rs1_addr    = 5'($urandom_range(0, 7));
            in_rs2_addr    = 5'($urandom_range(0, 7));
            in_rd_addr     = 5'($urandom_range(0, 31));
            in_rd_we       = 1'($urandom_range(0, 1));
            in_ctrl        = $urandom;
            ex_fwd_we      = 1'($urandom_range(0, 1));
            ex_fwd_pending = ($urandom_range(0, 3) == 0);
            ex_fwd_rd      = 5'($urandom_range(0, 7));
            ex_fwd_data    = $urandom;
            mem_fwd_we     = 1'($urandom_range(0, 1));
            mem_fwd_rd     = 5'($urandom_range(0, 7));
            mem_fwd_data   = $urandom;
            wb_we          = 1'($urandom_range(0, 1));
            wb_rd          = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(1, 7)] = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 32, operand/result data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter CTRL_WIDTH, default 32, opaque decoded-control bundle width, passed through unmodified.
REQ-004 SHALL have ports: clk  in  1  the single clock; all state updates on posedge.
REQ-005 SHALL have ports: rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have ports: start  in  1  run enable; 0 freezes all state and forces in_ready=0.
REQ-007 SHALL have ports: flush  in  1  kill the held output instruction.
REQ-008 SHALL have ports: in_valid/in_ready  in/out  1/1  upstream decode handshake.
REQ-009 SHALL have ports: in_rs1_addr, in_rs2_addr, in_rd_addr  in  REG_ADDR_WIDTH each  source and destination registers.
REQ-010 SHALL have ports: in_rd_we  in  1  instruction writes rd; in_ctrl  in  CTRL_WIDTH  passthrough control.
REQ-011 SHALL have ports: rf_rs1_addr, rf_rs2_addr  out  REG_ADDR_WIDTH  register-file read addresses; rf_rs1_data, rf_rs2_data  in  REGISTER_WIDTH  combinational read data.
REQ-012 SHALL have ports: ex_fwd_we, ex_fwd_pending  in  1/1; ex_fwd_rd  in  REG_ADDR_WIDTH; ex_fwd_data  in  REGISTER_WIDTH  execute-stage result; pending=1 means data not yet available (load).
REQ-013 SHALL have ports: mem_fwd_we  in  1; mem_fwd_rd  in  REG_ADDR_WIDTH; mem_fwd_data  in  REGISTER_WIDTH  memory-stage result.
REQ-014 SHALL have ports: wb_we  in  1; wb_rd  in  REG_ADDR_WIDTH; wb_data  in  REGISTER_WIDTH  writeback port, the same signals driven into the register file this cycle.
REQ-015 SHALL have ports: out_valid/out_ready  out/in  1/1  downstream execute handshake.
REQ-016 SHALL have ports: out_rs1_data, out_rs2_data  out  REGISTER_WIDTH; out_rd_addr  out  REG_ADDR_WIDTH; out_rd_we  out  1; out_ctrl  out  CTRL_WIDTH  registered outputs.
REQ-017 SHALL have ports: stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-018 rf_rs1_addr/rf_rs2_addr SHALL equal in_rs1_addr/in_rs2_addr combinationally.
REQ-019 Operand resolution per source: address 0 -> 0; else first match in priority ex_fwd (ex_fwd_we & rd equal) > mem_fwd > wb > rf data.
REQ-020 A match on the ex source with ex_fwd_pending=1 SHALL raise hazard; x0 never raises hazard.
REQ-021 in_ready SHALL = start & !hazard & (!out_valid | out_ready) & !flush.
REQ-022 On in_valid & in_ready the output register SHALL load resolved operands, rd, rd_we, ctrl and set out_valid=1 next cycle (1-cycle latency).
REQ-023 Output handshake completes on out_valid & out_ready; if no new load occurs the same cycle, out_valid SHALL clear.
REQ-024 While out_valid & !out_ready, all out_* SHALL hold stable.
REQ-025 Hazard with free output: out_valid SHALL clear (bubble) and the input SHALL not be accepted.
REQ-026 flush SHALL clear out_valid next cycle and block acceptance that cycle; flush overrides load and hold.
REQ-027 stall_cnt SHALL increment when start & in_valid & hazard; saturate at 16'hFFFF.
REQ-028 start=0 SHALL hold every register; flush still applies only when start=1.
REQ-029 Data fields of a non-valid output are don't-care; verification checks them only when out_valid=1.

Reset
REQ-030 rst_n=0 at posedge SHALL set out_valid=0, stall_cnt=0, out_rs1_data=out_rs2_data=0, out_rd_addr=0, out_rd_we=0, out_ctrl=0; reset mid-transfer discards the held instruction.
REQ-031 Reset SHALL take priority over flush, start and handshakes.

Verification
REQ-032 Plain read: rf x3=5, x4=7, no fwd, rs1=3 rs2=4 -> next cycle out_valid=1, out_rs1=5, out_rs2=7.
REQ-033 Priority: ex rd=3 data=9, mem rd=3 data=8, wb rd=3 data=6, rf=5 -> out_rs1=9; drop ex -> 8; drop mem -> 6.
REQ-034 x0: rs1=0 with ex/mem/wb rd=0 data=0xFFFFFFFF -> out_rs1=0, no hazard.
REQ-035 Load-use: ex rd=4 pending=1, rs2=4 for 3 cycles -> in_ready=0, out_valid=0, stall_cnt=3; pending drops -> accepted, out_rs2=ex data.
REQ-036 Backpressure + flush: out_ready=0 for 4 cycles -> outputs stable, in_ready=0; flush -> out_valid=0 next cycle.
REQ-037 Reset mid-stall with stall_cnt=10 and out_valid=1 -> next cycle stall_cnt=0, out_valid=0.
